sargantana_set_ram_bank: RTL and testbench

Parametrised multi-way set storage for the instruction cache: one physical array holds all ways of a set, addressed by set index, with per-way write enables, a configurable read pipeline and a built-in sequential clear engine. It replaces per-way single-port set memories in the icache memory wrapper. It guarantees all ways read as zero after reset or flush, so valid/tag ways start clean without external initialisation.

---
 rtl/sargantana_set_ram_bank.sv | 102 ++++++++++
 tb/tb_sargantana_set_ram_bank.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sargantana_set_ram_bank.sv
// sargantana_set_ram_bank: multi-way icache set array with per-way write enables,
// 1- or 2-cycle read pipeline and a sequential clear engine run after reset/flush.
module sargantana_set_ram_bank #(
   parameter int N_WAYS     = 4,
   parameter int WAY_WIDTH  = 128,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int OUT_REG    = 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_i,
   input  logic                        we_i,
   input  logic [N_WAYS-1:0]           way_en_i,
   input  logic [ADDR_WIDTH-1:0]       addr_i,
   input  logic [WAY_WIDTH-1:0]        data_i,
   input  logic                        flush_i,
   output logic                        ready_o,
   output logic                        rvalid_o,
   output logic [N_WAYS*WAY_WIDTH-1:0] data_o
);
   localparam int DW = N_WAYS * WAY_WIDTH;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [DW-1:0]         r_mem [DEPTH];
   logic                  w_acc, w_wr, w_rd;
   logic                  r_v1;
   logic [DW-1:0]         r_d1;

   assign ready_o = (r_state == IDLE);
   // flush wins over a same-cycle request; out-of-range indices are dropped
   assign w_acc   = ready_o && req_i && !flush_i && (32'(addr_i) < DEPTH);
   assign w_wr    = w_acc && we_i;
   assign w_rd    = w_acc && !we_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (flush_i) begin
         w_state_nxt = CLEAR;
         w_cnt_nxt   = '0;
      end else if (r_state == CLEAR) begin
         w_cnt_nxt = r_cnt + 1'b1;
         if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      end
   end

   // array itself has no reset; the clear engine zeroes it before any access
   always_ff @(posedge clk_i) begin
      if (r_state == CLEAR) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr) begin
         for (int w = 0; w < N_WAYS; w++)
            if (way_en_i[w]) r_mem[addr_i][w*WAY_WIDTH +: WAY_WIDTH] <= data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_v1 <= 1'b0;
         r_d1 <= '0;
      end else begin
         r_v1 <= w_rd;
         if (w_rd) r_d1 <= r_mem[addr_i];
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic          r_v2;
      logic [DW-1:0] r_d2;
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_v2 <= 1'b0;
            r_d2 <= '0;
         end else begin
            r_v2 <= r_v1;
            if (r_v1) r_d2 <= r_d1;
         end
      end
      assign rvalid_o = r_v2;
      assign data_o   = r_d2;
   end else begin : g_no_out_reg
      assign rvalid_o = r_v1;
      assign data_o   = r_d1;
   end
endmodule

// File: tb/tb_sargantana_set_ram_bank.sv
// tb_sargantana_set_ram_bank: random and directed checks of both read latencies
// against an abstract array model with a clear countdown and read-latency history.
module tb_sargantana_set_ram_bank;
   localparam int NW = 4, WW = 128, D = 64, AW = 6, DW = NW * WW;

   logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, flush = 1'b0;
   logic [NW-1:0] en = '0;
   logic [AW-1:0] addr = '0;
   logic [WW-1:0] wdata = '0;
   logic rdy1, rv1, rdy0, rv0;
   logic [DW-1:0] do1, do0;

   int n_chk = 0, n_fail = 0;

   logic [DW-1:0] mem [D];
   int clear_left;
   bit p_v, e_v1, e_v0;
   logic [DW-1:0] p_d, e_d1, e_d0;

   always #5 clk = ~clk;

   sargantana_set_ram_bank #(.N_WAYS(NW), .WAY_WIDTH(WW), .DEPTH(D), .OUT_REG(1)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .way_en_i(en), .addr_i(addr),
      .data_i(wdata), .flush_i(flush), .ready_o(rdy1), .rvalid_o(rv1), .data_o(do1));

   sargantana_set_ram_bank #(.N_WAYS(NW), .WAY_WIDTH(WW), .DEPTH(D), .OUT_REG(0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .way_en_i(en), .addr_i(addr),
      .data_i(wdata), .flush_i(flush), .ready_o(rdy0), .rvalid_o(rv0), .data_o(do0));

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      check("ready_lat2", DW'(rdy1), DW'(clear_left == 0));
      check("ready_lat1", DW'(rdy0), DW'(clear_left == 0));
      check("rvalid_lat2", DW'(rv1), DW'(e_v1));
      check("rvalid_lat1", DW'(rv0), DW'(e_v0));
      check("data_lat2", do1, e_d1);
      check("data_lat1", do0, e_d0);
   endtask

   task automatic model_reset();
      foreach (mem[i]) mem[i] = '0;
      clear_left = D;
      p_v = 0; e_v1 = 0; e_v0 = 0;
      p_d = '0; e_d1 = '0; e_d0 = '0;
   endtask

   task automatic tick(input bit r, input bit w, input logic [NW-1:0] e, input int a,
                       input logic [WW-1:0] d, input bit f);
      bit acc;
      logic [DW-1:0] rd;
      req = r; we = w; en = e; addr = AW'(a); wdata = d; flush = f;
      acc = (clear_left == 0) && r && !f;
      rd = mem[a];
      @(posedge clk);
      #1;
      e_v1 = p_v;
      if (p_v) e_d1 = p_d;
      p_v = acc && !w;
      p_d = rd;
      e_v0 = acc && !w;
      if (e_v0) e_d0 = rd;
      if (acc && w)
         for (int k = 0; k < NW; k++) if (e[k]) mem[a][k*WW +: WW] = d;
      if (f) begin
         clear_left = D;
         foreach (mem[i]) mem[i] = '0;
      end else if (clear_left > 0) clear_left--;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, '0, 0, '0, 0);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1; req = 1'b0; flush = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [WW-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      model_reset();
      do_reset();
      idle(D);
      for (int a = 0; a < D; a++) tick(1, 0, '0, a, '0, 0);
      idle(2);
      tick(1, 1, 4'b0101, 5, {16{8'hA5}}, 0);
      tick(1, 0, '0, 5, '0, 0);
      idle(2);
      tick(1, 0, '0, 5, '0, 0);
      tick(1, 1, 4'b0010, 5, rnd_word(), 0);
      idle(5);
      tick(1, 1, 4'b0000, 5, rnd_word(), 0);
      tick(1, 0, '0, 5, '0, 0);
      for (int a = 0; a < D; a++) tick(1, 1, 4'hF, a, rnd_word(), 0);
      tick(1, 0, '0, 9, '0, 0);
      tick(1, 0, '0, 7, '0, 1);
      idle(D);
      for (int a = 0; a < D; a++) tick(1, 0, '0, a, '0, 0);
      idle(2);
      tick(0, 0, '0, 0, '0, 1);
      idle(30);
      tick(0, 0, '0, 0, '0, 1);
      idle(D + 1);
      for (int i = 0; i < 1500; i++)
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, NW'($urandom),
              $urandom_range(0, D - 1), rnd_word(), $urandom_range(0, 149) == 0);
      idle(D);
      tick(0, 0, '0, 0, '0, 1);
      idle(20);
      do_reset();
      idle(D);
      tick(1, 1, 4'hF, 3, rnd_word(), 0);
      tick(1, 0, '0, 3, '0, 0);
      do_reset();
      idle(D + 2);
      tick(1, 0, '0, 3, '0, 0);
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
